// File: rtl/fcs_pkg.sv
// Shared FCS32 definitions: constants, sequencer state/beat types, and the byte-wide CRC helpers.
// CRC is the reflected Ethernet polynomial; fcs32_brev turns the final register into wire byte order.
package fcs_pkg;

    localparam logic        LO   = 1'b0;
    localparam logic        HI   = 1'b1;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY = 32'hEDB8_8320;

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_e;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] dat;
    } beat_t;

    function automatic logic [31:0] fcs32_8(input logic [7:0] dat, input logic [31:0] crc);
        logic [31:0] c;
        c = crc ^ {24'h0, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Complement, then put the low CRC byte in [31:24] so bytes go out MSB-field first.
    function automatic logic [31:0] fcs32_brev(input logic [31:0] crc);
        logic [31:0] f;
        f = ~crc;
        return {f[7:0], f[15:8], f[23:16], f[31:24]};
    endfunction

endpackage

// File: rtl/fcs32_8_obuf.sv
// Single-entry output register: loads on adv, one cycle latency.
// Holds its beat while valid and not ready; adv = !valid | ready.
module fcs32_8_obuf
    import fcs_pkg::*;
(
    input  logic  pclk_i,
    input  logic  prst_i,
    input  logic  ld_i,
    input  beat_t ld_beat_i,
    input  logic  out_rdy_i,
    output logic  adv_o,
    output logic  out_val_o,
    output beat_t out_beat_o
);

    logic  val_q;
    beat_t beat_q;

    assign adv_o      = !val_q | out_rdy_i;
    assign out_val_o  = val_q;
    assign out_beat_o = beat_q;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            val_q  <= LO;
            beat_q <= '0;
        end else if (adv_o) begin
            val_q <= ld_i;
            if (ld_i) begin
                beat_q <= ld_beat_i;
            end
        end
    end

endmodule

// File: rtl/fcs32_8_tx_seq.sv
// TX sequencer: passes sof/eof-framed bytes, zero-pads to MIN_LEN, appends 4 FCS bytes.
// Latency 1 cycle via the output register; in_rdy_o follows downstream ready combinationally.
module fcs32_8_tx_seq
    import fcs_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    input  logic [7:0]       in_dat_i,
    input  logic             in_sof_i,
    input  logic             in_eof_i,
    input  logic             in_val_i,
    output logic             in_rdy_o,
    output logic [7:0]       out_dat_o,
    output logic             out_sof_o,
    output logic             out_eof_o,
    output logic             out_val_o,
    input  logic             out_rdy_i,
    output logic             err_o,
    output logic [CNT_W-1:0] frm_cnt_o
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

    state_e            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              adv;
    logic              acc;
    logic              ld;
    beat_t             ld_beat;
    beat_t             obeat;
    logic [LEN_W-1:0]  len_inc;
    logic [31:0]       f;

    assign in_rdy_o  = !prst_i & adv & (state_q == IDLE || state_q == DATA);
    assign acc       = in_val_i & in_rdy_o;
    assign len_inc   = (&len_q) ? len_q : len_q + LEN_W'(1);
    assign f         = fcs32_brev(crc_q);

    assign out_dat_o = obeat.dat;
    assign out_sof_o = obeat.sof;
    assign out_eof_o = obeat.eof;
    assign err_o     = err_q;
    assign frm_cnt_o = cnt_q;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = LO;
        ld      = LO;
        ld_beat = '0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (in_sof_i) begin
                        ld      = HI;
                        ld_beat = '{sof: HI, eof: LO, dat: in_dat_i};
                        crc_d   = fcs32_8(in_dat_i, ONES);
                        len_d   = len_inc;
                        if (in_eof_i) begin
                            state_d = (len_inc < MIN_L) ? PAD : FCS;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        err_d = HI;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    ld      = HI;
                    ld_beat = '{sof: LO, eof: LO, dat: in_dat_i};
                    crc_d   = fcs32_8(in_dat_i, crc_q);
                    len_d   = len_inc;
                    err_d   = in_sof_i;
                    if (in_eof_i) begin
                        state_d = (len_inc < MIN_L) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                if (adv) begin
                    ld    = HI;
                    crc_d = fcs32_8(8'h00, crc_q);
                    len_d = len_inc;
                    if (len_inc >= MIN_L) begin
                        state_d = FCS;
                    end
                end
            end
            FCS: begin
                if (adv) begin
                    ld          = HI;
                    ld_beat.eof = (idx_q == 2'd3);
                    unique case (idx_q)
                        2'd0:    ld_beat.dat = f[31:24];
                        2'd1:    ld_beat.dat = f[23:16];
                        2'd2:    ld_beat.dat = f[15:8];
                        default: ld_beat.dat = f[7:0];
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        crc_d   = ONES;
                        len_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_q <= IDLE;
            crc_q   <= ONES;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= LO;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    fcs32_8_obuf u_obuf (
        .pclk_i     (pclk_i),
        .prst_i     (prst_i),
        .ld_i       (ld),
        .ld_beat_i  (ld_beat),
        .out_rdy_i  (out_rdy_i),
        .adv_o      (adv),
        .out_val_o  (out_val_o),
        .out_beat_o (obeat)
    );

endmodule

// File: tb/tb_fcs32_8_tx_seq.sv
// Bench for fcs32_8_tx_seq: two instances (MIN_LEN=0 and MIN_LEN=60) driven by directed frames;
// expected beats are queued at stimulus time and popped by a monitor as the DUT hands them over.
module tb_fcs32_8_tx_seq;

    logic        pclk = 1'b0;
    logic        rst     [2];
    logic [7:0]  in_dat  [2];
    logic        in_sof  [2];
    logic        in_eof  [2];
    logic        in_val  [2];
    logic        in_rdy  [2];
    logic [7:0]  out_dat [2];
    logic        out_sof [2];
    logic        out_eof [2];
    logic        out_val [2];
    logic        out_rdy [2];
    logic        err     [2];
    logic [15:0] frm_cnt [2];

    logic [9:0]  exp_q [2][$];
    logic [7:0]  pl [$];
    bit          rnd     [2];
    bit          mon_off [2];
    int          errcnt  [2];
    int          tests = 0;
    int          fails = 0;

    always #5 pclk = ~pclk;

    fcs32_8_tx_seq #(.MIN_LEN(0), .LEN_W(16), .CNT_W(16)) u0 (
        .pclk_i(pclk), .prst_i(rst[0]),
        .in_dat_i(in_dat[0]), .in_sof_i(in_sof[0]), .in_eof_i(in_eof[0]),
        .in_val_i(in_val[0]), .in_rdy_o(in_rdy[0]),
        .out_dat_o(out_dat[0]), .out_sof_o(out_sof[0]), .out_eof_o(out_eof[0]),
        .out_val_o(out_val[0]), .out_rdy_i(out_rdy[0]),
        .err_o(err[0]), .frm_cnt_o(frm_cnt[0])
    );

    fcs32_8_tx_seq #(.MIN_LEN(60), .LEN_W(16), .CNT_W(16)) u1 (
        .pclk_i(pclk), .prst_i(rst[1]),
        .in_dat_i(in_dat[1]), .in_sof_i(in_sof[1]), .in_eof_i(in_eof[1]),
        .in_val_i(in_val[1]), .in_rdy_o(in_rdy[1]),
        .out_dat_o(out_dat[1]), .out_sof_o(out_sof[1]), .out_eof_o(out_eof[1]),
        .out_val_o(out_val[1]), .out_rdy_i(out_rdy[1]),
        .err_o(err[1]), .frm_cnt_o(frm_cnt[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic push_beat(input int d, input logic sof, input logic eof, input logic [7:0] dat);
        exp_q[d].push_back({sof, eof, dat});
    endtask

    // Bit-serial reference CRC over payload plus zero pad, FCS sent low byte first.
    task automatic push_frame(input int d, input int minlen);
        logic [7:0]  b [$];
        logic [31:0] c;
        logic        fb;
        b = pl;
        while (b.size() < minlen) b.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            push_beat(d, i == 0, 1'b0, b[i]);
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        push_beat(d, 1'b0, 1'b0, c[7:0]);
        push_beat(d, 1'b0, 1'b0, c[15:8]);
        push_beat(d, 1'b0, 1'b0, c[23:16]);
        push_beat(d, 1'b0, 1'b1, c[31:24]);
    endtask

    task automatic send_beat(input int d, input logic [7:0] dat, input logic sof, input logic eof);
        bit acc = 1'b0;
        int n = 0;
        in_dat[d] = dat;
        in_sof[d] = sof;
        in_eof[d] = eof;
        in_val[d] = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge pclk);
            acc = in_rdy[d];
            @(posedge pclk);
            #1;
            n++;
        end
        in_val[d] = 1'b0;
        in_sof[d] = 1'b0;
        in_eof[d] = 1'b0;
        chk($sformatf("accept_d%0d", d), 32'(acc), 32'd1);
    endtask

    task automatic drive_frame(input int d);
        foreach (pl[i]) send_beat(d, pl[i], i == 0, i == pl.size() - 1);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while ((exp_q[d].size() != 0 || out_val[d]) && n < 2000) begin
            @(posedge pclk);
            #1;
            n++;
        end
        chk($sformatf("drain_left_d%0d", d), 32'(exp_q[d].size()), 32'd0);
    endtask

    task automatic rdy_gen(input int d);
        forever begin
            @(posedge pclk);
            #1;
            out_rdy[d] = rnd[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic mon(input int d);
        logic [9:0] cur, held_v, e;
        bit         held = 1'b0;
        int         nb = 0;
        forever begin
            @(negedge pclk);
            cur = {out_sof[d], out_eof[d], out_dat[d]};
            if (rst[d] || mon_off[d]) begin
                held = 1'b0;
            end else begin
                if (err[d]) errcnt[d]++;
                if (held) chk($sformatf("stall_hold_d%0d", d), 32'({out_val[d], cur}), 32'({1'b1, held_v}));
                held = 1'b0;
                if (out_val[d]) begin
                    if (out_rdy[d]) begin
                        if (exp_q[d].size() == 0) begin
                            chk($sformatf("extra_beat_d%0d_val%0h", d, cur), 32'(exp_q[d].size()), 32'd1);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk($sformatf("beat_d%0d_n%0d", d, nb), 32'(cur), 32'(e));
                        end
                        nb++;
                    end else begin
                        held   = 1'b1;
                        held_v = cur;
                    end
                end
            end
        end
    endtask

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_dat[d] = 8'h00; in_sof[d] = 1'b0; in_eof[d] = 1'b0;
            in_val[d] = 1'b0; out_rdy[d] = 1'b1; rnd[d] = 1'b0; mon_off[d] = 1'b0; errcnt[d] = 0;
        end
        fork
            mon(0);
            mon(1);
            rdy_gen(0);
            rdy_gen(1);
        join_none
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_val_d%0d", d), 32'(out_val[d]), 32'd0);
            chk($sformatf("rst_flags_d%0d", d), 32'({out_dat[d], out_sof[d], out_eof[d], err[d]}), 32'd0);
            chk($sformatf("rst_cnt_d%0d", d), 32'(frm_cnt[d]), 32'd0);
            chk($sformatf("rst_rdy_d%0d", d), 32'(in_rdy[d]), 32'd0);
        end
        repeat (3) @(posedge pclk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // "123456789", no padding: check value 0xCBF43926 on the wire as 26 39 F4 CB.
        pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        foreach (pl[i]) push_beat(0, i == 0, 1'b0, pl[i]);
        push_beat(0, 1'b0, 1'b0, 8'h26);
        push_beat(0, 1'b0, 1'b0, 8'h39);
        push_beat(0, 1'b0, 1'b0, 8'hF4);
        push_beat(0, 1'b0, 1'b1, 8'hCB);
        drive_frame(0);
        drain(0);
        chk("t1_frm_cnt", 32'(frm_cnt[0]), 32'd1);

        // Reset while padding: partial frame vanishes, counter stays at zero.
        mon_off[1] = 1'b1;
        send_beat(1, 8'hAA, 1'b1, 1'b1);
        repeat (5) @(posedge pclk);
        #2;
        chk("rst_mid_busy", 32'({out_val[1], in_rdy[1]}), 32'b10);
        rst[1] = 1'b1;
        #1;
        chk("rst_mid_val", 32'(out_val[1]), 32'd0);
        chk("rst_mid_flags", 32'({out_dat[1], out_sof[1], out_eof[1]}), 32'd0);
        chk("rst_mid_cnt", 32'(frm_cnt[1]), 32'd0);
        chk("rst_mid_rdy", 32'(in_rdy[1]), 32'd0);
        @(posedge pclk);
        #1;
        rst[1] = 1'b0;
        exp_q[1].delete();
        mon_off[1] = 1'b0;

        // Single byte padded to 60 then FCS; input held off for the whole 63-cycle tail.
        pl = '{8'h00};
        push_frame(1, 60);
        send_beat(1, 8'h00, 1'b1, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 63; i++) begin
            @(negedge pclk);
            if (in_rdy[1]) ok = 1'b0;
        end
        chk("t2_rdy_low_63", 32'(ok), 32'd1);
        @(negedge pclk);
        chk("t2_rdy_back", 32'(in_rdy[1]), 32'd1);
        @(posedge pclk);
        #1;
        drain(1);
        chk("t2_frm_cnt", 32'(frm_cnt[1]), 32'd1);

        // Same nine bytes with random downstream stalls.
        rnd[0] = 1'b1;
        pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(0, 0);
        drive_frame(0);
        drain(0);
        rnd[0] = 1'b0;
        chk("t3_frm_cnt", 32'(frm_cnt[0]), 32'd2);

        // Stray beat without sof in IDLE is dropped with a single err pulse.
        send_beat(0, 8'h77, 1'b0, 1'b0);
        pl = '{8'h10, 8'h20, 8'h30};
        push_frame(0, 0);
        drive_frame(0);
        drain(0);
        chk("t4_err_cycles", 32'(errcnt[0]), 32'd1);
        chk("t4_frm_cnt", 32'(frm_cnt[0]), 32'd3);

        // Second sof mid-frame: kept as data, one err pulse.
        pl = '{8'h41, 8'h42, 8'h43, 8'h44};
        push_frame(0, 0);
        send_beat(0, 8'h41, 1'b1, 1'b0);
        send_beat(0, 8'h42, 1'b1, 1'b0);
        send_beat(0, 8'h43, 1'b0, 1'b0);
        send_beat(0, 8'h44, 1'b0, 1'b1);
        drain(0);
        chk("t5_err_cycles", 32'(errcnt[0]), 32'd2);
        chk("t5_frm_cnt", 32'(frm_cnt[0]), 32'd4);

        // Short multi-byte frame padded, under random stalls.
        rnd[1] = 1'b1;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A};
        push_frame(1, 60);
        drive_frame(1);
        drain(1);
        rnd[1] = 1'b0;
        chk("t7_frm_cnt", 32'(frm_cnt[1]), 32'd2);
        chk("t7_no_err_d1", 32'(errcnt[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
